// File: rtl/demux1to4_tdm.sv
// Registered 1-to-4 demultiplexer: direct lane select or frame-aligned TDM slot recovery.
// Every output is a register; a word accepted at edge k appears on its lane after edge k.
module demux1to4_tdm #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_i,
  input  logic             in_valid_i,
  input  logic             sync_i,
  input  logic             mode_i,
  input  logic [1:0]       sel_i,
  output logic [WIDTH-1:0] out0_o,
  output logic [WIDTH-1:0] out1_o,
  output logic [WIDTH-1:0] out2_o,
  output logic [WIDTH-1:0] out3_o,
  output logic [3:0]       out_strobe_o,
  output logic             frame_valid_o,
  output logic             frame_err_o,
  output logic [1:0]       slot_o,
  output logic             busy_o
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              slot_q, slot_d;
  logic [3:0]              strobe_q, strobe_d;
  logic                    fv_q, fv_d;
  logic                    fe_q, fe_d;
  logic                    wr_en;
  logic [1:0]              wr_lane;
  logic [3:0][WIDTH-1:0]   lane_q;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    fv_d    = 1'b0;
    fe_d    = 1'b0;
    wr_en   = 1'b0;
    wr_lane = 2'd0;
    if (!mode_i) begin
      // Direct mode always drops frame alignment, even on idle cycles.
      state_d = IDLE;
      slot_d  = 2'd0;
      if (in_valid_i) begin
        wr_en   = 1'b1;
        wr_lane = sel_i;
      end
    end else if (in_valid_i) begin
      if (sync_i) begin
        wr_en   = 1'b1;
        wr_lane = 2'd0;
        slot_d  = 2'd1;
        state_d = RUN;
        fe_d    = (state_q == RUN) && (slot_q != 2'd0);
      end else if (state_q == RUN) begin
        wr_en   = 1'b1;
        wr_lane = slot_q;
        slot_d  = slot_q + 2'd1;
        fv_d    = (slot_q == 2'd3);
      end
    end
    strobe_d = wr_en ? (4'b0001 << wr_lane) : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      slot_q   <= 2'd0;
      strobe_q <= 4'b0000;
      fv_q     <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      strobe_q <= strobe_d;
      fv_q     <= fv_d;
      fe_q     <= fe_d;
    end
  end

  // The one-hot strobe doubles as the per-lane write enable.
  for (genvar g = 0; g < 4; g++) begin : g_lane
    always_ff @(posedge clk) begin
      if (rst)              lane_q[g] <= '0;
      else if (strobe_d[g]) lane_q[g] <= in_i;
    end
  end

  assign out0_o        = lane_q[0];
  assign out1_o        = lane_q[1];
  assign out2_o        = lane_q[2];
  assign out3_o        = lane_q[3];
  assign out_strobe_o  = strobe_q;
  assign frame_valid_o = fv_q;
  assign frame_err_o   = fe_q;
  assign slot_o        = slot_q;
  assign busy_o        = (state_q == RUN);

endmodule
